// File: rtl/pipe_barrel_shifter_pkg.sv
// Shared op-code definitions for the pipelined barrel shifter.
// Optional carry tracking is enabled with the SHIFTER_CARRY_EN macro.
package shifter_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_SLL = 3'b000;
    localparam op_t OP_SRL = 3'b001;
    localparam op_t OP_SRA = 3'b010;
    localparam op_t OP_ROL = 3'b011;
    localparam op_t OP_ROR = 3'b100;

endpackage

// File: rtl/pipe_barrel_shifter_if.sv
// Request/response stream bundle of the barrel shifter; the shifter is the slave.
// out_carry exists only when SHIFTER_CARRY_EN is defined.
interface pipe_barrel_shifter_if
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    localparam int SH_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SH_W-1:0]  in_shamt;
    op_t              in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
`ifdef SHIFTER_CARRY_EN
    logic             out_carry;

    modport master (
        output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_carry
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_carry
    );
`else
    modport master (
        output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
`endif

endinterface

// File: rtl/pipe_barrel_shifter_stage.sv
// One pipeline level of the barrel shifter: conditionally shifts by 2^K and registers the payload.
// Carry tracking is compiled in with SHIFTER_CARRY_EN.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int K     = 0,
    localparam int SH_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic             ready_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [SH_W-1:0]  shamt_i,
    input  op_t              op_i,
    input  logic [TAG_W-1:0] tag_i,
`ifdef SHIFTER_CARRY_EN
    input  logic             carry_i,
    output logic             carry_o,
`endif
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [SH_W-1:0]  shamt_o,
    output op_t              op_o,
    output logic [TAG_W-1:0] tag_o
);
    localparam int STEP = 1 << K;

    logic             advance;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [SH_W-1:0]  shamt_q;
    op_t              op_q;
    logic [TAG_W-1:0] tag_q;

    assign advance = !valid_q || ready_i;

    always_comb begin
        data_d = data_i;
        if (shamt_i[K]) begin
            case (op_i)
                OP_SLL:  data_d = data_i << STEP;
                OP_SRL:  data_d = data_i >> STEP;
                OP_SRA:  data_d = $unsigned($signed(data_i) >>> STEP);
                OP_ROL:  data_d = {data_i[WIDTH-STEP-1:0], data_i[WIDTH-1:WIDTH-STEP]};
                OP_ROR:  data_d = {data_i[STEP-1:0], data_i[WIDTH-1:STEP]};
                default: data_d = data_i;
            endcase
        end
    end

`ifdef SHIFTER_CARRY_EN
    logic carry_q;
    logic carry_d;

    // Carry records the last bit that left the word at this level, or holds if no shift happens here.
    always_comb begin
        carry_d = carry_i;
        if (shamt_i[K]) begin
            case (op_i)
                OP_SLL:  carry_d = data_i[WIDTH-STEP];
                OP_SRL:  carry_d = data_i[STEP-1];
                OP_SRA:  carry_d = data_i[STEP-1];
                OP_ROL:  carry_d = data_d[0];
                OP_ROR:  carry_d = data_d[WIDTH-1];
                default: carry_d = carry_i;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_q <= 1'b0;
        end else if (advance && valid_i) begin
            carry_q <= carry_d;
        end
    end

    assign carry_o = carry_q;
`endif

    // Payload is only captured for real requests, so bubbles leave the last result in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            op_q    <= OP_SLL;
            tag_q   <= '0;
        end else if (advance) begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q  <= data_d;
                shamt_q <= shamt_i;
                op_q    <= op_i;
                tag_q   <= tag_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign shamt_o = shamt_q;
    assign op_o    = op_q;
    assign tag_o   = tag_q;

endmodule

// File: rtl/pipe_barrel_shifter.sv
// Fully pipelined barrel shifter, one shift level per stage, with a valid/ready stream.
// Define SHIFTER_CARRY_EN to add the out_carry result.
module pipe_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    pipe_barrel_shifter_if.slave  bus
);
    localparam int SH_W = $clog2(WIDTH);

    logic [SH_W:0]              validVec;
    logic [SH_W-1:0]            stageReady;
    logic [SH_W:0][WIDTH-1:0]   dataVec;
    logic [SH_W:0][SH_W-1:0]    shamtVec;
    op_t  [SH_W:0]              opVec;
    logic [SH_W:0][TAG_W-1:0]   tagVec;
    logic                       unusedTail;

    assign validVec[0] = bus.in_valid;
    assign dataVec[0]  = bus.in_data;
    assign shamtVec[0] = bus.in_shamt;
    assign opVec[0]    = bus.in_op;
    assign tagVec[0]   = bus.in_tag;

`ifdef SHIFTER_CARRY_EN
    logic [SH_W:0] carryVec;
    assign carryVec[0] = 1'b0;
`endif

    // Downstream readiness is derived from the registered valid bits, avoiding a ripple through stage outputs.
    for (genvar k = 0; k < SH_W; k++) begin : g_stage
        if (k == SH_W - 1) begin : g_last
            assign stageReady[k] = bus.out_ready;
        end else begin : g_mid
            assign stageReady[k] = bus.out_ready || !(&validVec[SH_W:k+2]);
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .K     (k)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .valid_i (validVec[k]),
            .ready_i (stageReady[k]),
            .data_i  (dataVec[k]),
            .shamt_i (shamtVec[k]),
            .op_i    (opVec[k]),
            .tag_i   (tagVec[k]),
`ifdef SHIFTER_CARRY_EN
            .carry_i (carryVec[k]),
            .carry_o (carryVec[k+1]),
`endif
            .valid_o (validVec[k+1]),
            .data_o  (dataVec[k+1]),
            .shamt_o (shamtVec[k+1]),
            .op_o    (opVec[k+1]),
            .tag_o   (tagVec[k+1])
        );
    end

    assign bus.in_ready  = !validVec[1] || stageReady[0];
    assign bus.out_valid = validVec[SH_W];
    assign bus.out_data  = dataVec[SH_W];
    assign bus.out_tag   = tagVec[SH_W];
`ifdef SHIFTER_CARRY_EN
    assign bus.out_carry = carryVec[SH_W];
`endif

    assign unusedTail = ^{shamtVec[SH_W], opVec[SH_W]};

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Self-checking bench for pipe_barrel_shifter: directed cases plus randomized traffic against a reference model.
// Carry results are checked as well when SHIFTER_CARRY_EN is defined.
module tb_pipe_barrel_shifter;

    localparam int WIDTH = 32;
    localparam int TAG_W = 4;
    localparam int SH_W  = 5;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] tag;
        logic             carry;
    } expect_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   testsRun = 0;
    int   testsFailed = 0;
    expect_t expQ[$];

    always #5 clk = ~clk;

    pipe_barrel_shifter_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus();

    pipe_barrel_shifter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Reference: whole-word shift by the full amount; carry is the last bit that left the word.
    function automatic expect_t refModel(logic [WIDTH-1:0] d, logic [SH_W-1:0] sh,
                                         logic [2:0] op, logic [TAG_W-1:0] tag);
        expect_t e;
        int n;
        n = int'(sh);
        e.data = d;
        e.tag = tag;
        e.carry = 1'b0;
        if (n != 0) begin
            case (op)
                3'd0: begin e.data = d << n; e.carry = d[WIDTH-n]; end
                3'd1: begin e.data = d >> n; e.carry = d[n-1]; end
                3'd2: begin e.data = $unsigned($signed(d) >>> n); e.carry = d[n-1]; end
                3'd3: begin e.data = (d << n) | (d >> (WIDTH - n)); e.carry = e.data[0]; end
                3'd4: begin e.data = (d >> n) | (d << (WIDTH - n)); e.carry = e.data[WIDTH-1]; end
                default: ;
            endcase
        end
        return e;
    endfunction

    task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: got timeout, expected handshake", name);
    endtask

    // Scoreboard: pushes accepted requests, pops and compares on every delivered result, checks hold stability.
    initial begin : scoreboard
        expect_t e;
        logic holdPrev;
        logic [WIDTH-1:0] holdData;
        logic [TAG_W-1:0] holdTag;
        logic holdCarry;
        holdPrev = 1'b0;
        holdData = '0;
        holdTag = '0;
        holdCarry = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                expQ.delete();
                holdPrev = 1'b0;
            end else begin
                if (holdPrev) begin
                    checkEq("hold out_valid", bus.out_valid, 1);
                    checkEq("hold out_data", bus.out_data, holdData);
                    checkEq("hold out_tag", bus.out_tag, holdTag);
`ifdef SHIFTER_CARRY_EN
                    checkEq("hold out_carry", bus.out_carry, holdCarry);
`endif
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (expQ.size() == 0) begin
                        testsRun++;
                        testsFailed++;
                        $display("[TB] FAIL unexpected result: got tag %0d data 0x%0h, expected none",
                                 bus.out_tag, bus.out_data);
                    end else begin
                        e = expQ.pop_front();
                        checkEq("model out_data", bus.out_data, e.data);
                        checkEq("model out_tag", bus.out_tag, e.tag);
`ifdef SHIFTER_CARRY_EN
                        checkEq("model out_carry", bus.out_carry, e.carry);
`endif
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    expQ.push_back(refModel(bus.in_data, bus.in_shamt, bus.in_op, bus.in_tag));
                end
                holdPrev = bus.out_valid && !bus.out_ready;
                holdData = bus.out_data;
                holdTag = bus.out_tag;
`ifdef SHIFTER_CARRY_EN
                holdCarry = bus.out_carry;
`endif
            end
        end
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic [SH_W-1:0] sh,
                                 input logic [2:0] op, input logic [TAG_W-1:0] tag);
        int waited;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data = d;
        bus.in_shamt = sh;
        bus.in_op = op;
        bus.in_tag = tag;
        waited = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.in_ready) failNow("accept");
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] expData,
                               input logic [TAG_W-1:0] expTag, input logic expCarry);
        int n;
        n = 1;
        @(negedge clk);
        while (!bus.out_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus.out_valid) begin
            failNow(name);
        end else begin
            checkEq({name, " latency"}, n, SH_W);
            checkEq({name, " data"}, bus.out_data, expData);
            checkEq({name, " tag"}, bus.out_tag, expTag);
`ifdef SHIFTER_CARRY_EN
            checkEq({name, " carry"}, bus.out_carry, expCarry);
`else
            if (expCarry === 1'bx) $display("[TB] note: undefined carry expectation for %s", name);
`endif
        end
    endtask

    initial begin : main
        int accepts;
        int stray;
        int cnt;
        logic acc;

        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_shamt = '0;
        bus.in_op = 3'd0;
        bus.in_tag = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        checkEq("reset out_valid", bus.out_valid, 0);
        checkEq("reset out_data", bus.out_data, 0);
        checkEq("reset out_tag", bus.out_tag, 0);
`ifdef SHIFTER_CARRY_EN
        checkEq("reset out_carry", bus.out_carry, 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        checkEq("in_ready after reset", bus.in_ready, 1);

        // Directed literal cases.
        applyStimulus(32'h0000_00F1, 5'd4, 3'd0, 4'd5);
        checkOutput("SLL F1<<4", 32'h0000_0F10, 4'd5, 1'b0);
        applyStimulus(32'h8000_0000, 5'd31, 3'd2, 4'd1);
        checkOutput("SRA 31", 32'hFFFF_FFFF, 4'd1, 1'b0);
        applyStimulus(32'h8000_0000, 5'd31, 3'd1, 4'd2);
        checkOutput("SRL 31", 32'h0000_0001, 4'd2, 1'b0);
        applyStimulus(32'h0000_0001, 5'd1, 3'd4, 4'd3);
        checkOutput("ROR 1", 32'h8000_0000, 4'd3, 1'b1);
        applyStimulus(32'h8000_0000, 5'd1, 3'd3, 4'd4);
        checkOutput("ROL 1", 32'h0000_0001, 4'd4, 1'b1);
        applyStimulus(32'h8000_0001, 5'd1, 3'd0, 4'd6);
        checkOutput("SLL carry", 32'h0000_0002, 4'd6, 1'b1);
        applyStimulus(32'h0000_0002, 5'd2, 3'd1, 4'd7);
        checkOutput("SRL carry", 32'h0000_0000, 4'd7, 1'b1);
        applyStimulus(32'hA5A5_0F0F, 5'd0, 3'd4, 4'd8);
        checkOutput("ROR shamt0", 32'hA5A5_0F0F, 4'd8, 1'b0);
        applyStimulus(32'h1234_5678, 5'd13, 3'd7, 4'd9);
        checkOutput("reserved op", 32'h1234_5678, 4'd9, 1'b0);

        // Back-to-back: eight results on eight consecutive cycles, tags in order.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    @(posedge clk);
                    #1;
                    bus.in_valid = 1'b1;
                    bus.in_data = $urandom;
                    bus.in_shamt = 5'($urandom_range(0, 31));
                    bus.in_op = 3'($urandom_range(0, 4));
                    bus.in_tag = 4'(i);
                end
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
            end
            begin
                cnt = 0;
                @(negedge clk);
                while (!bus.out_valid && cnt < 40) begin
                    cnt++;
                    @(negedge clk);
                end
                for (int i = 0; i < 8; i++) begin
                    checkEq("b2b out_valid", bus.out_valid, 1);
                    checkEq("b2b out_tag", bus.out_tag, i);
                    if (i < 7) @(negedge clk);
                end
            end
        join

        // Backpressure: pipeline fills to SH_W entries, then in_ready drops.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = $urandom;
        bus.in_shamt = 5'($urandom_range(0, 31));
        bus.in_op = 3'($urandom_range(0, 7));
        bus.in_tag = 4'd0;
        accepts = 0;
        repeat (12) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (acc) accepts++;
            @(posedge clk);
            #1;
            if (acc) begin
                bus.in_data = $urandom;
                bus.in_shamt = 5'($urandom_range(0, 31));
                bus.in_op = 3'($urandom_range(0, 7));
                bus.in_tag = 4'(accepts);
            end
        end
        checkEq("bp accepts", accepts, SH_W);
        @(negedge clk);
        checkEq("bp in_ready low", bus.in_ready, 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (15) @(negedge clk);
        checkEq("bp drained", expQ.size(), 0);

        // Reset with three requests in flight.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        applyStimulus(32'h0000_1111, 5'd3, 3'd0, 4'd1);
        applyStimulus(32'h0000_2222, 5'd4, 3'd1, 4'd2);
        applyStimulus(32'h0000_3333, 5'd5, 3'd3, 4'd3);
        repeat (6) @(posedge clk);
        #2;
        checkEq("pre-reset out_valid", bus.out_valid, 1);
        rst = 1'b1;
        #1;
        checkEq("async reset out_valid", bus.out_valid, 0);
        checkEq("async reset out_data", bus.out_data, 0);
        checkEq("async reset out_tag", bus.out_tag, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkEq("in_ready after mid reset", bus.in_ready, 1);
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid) stray++;
        end
        checkEq("no stale results", stray, 0);

        // Randomized traffic with random backpressure and all op codes.
        for (int it = 0; it < 600; it++) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (!bus.in_valid || acc) begin
                bus.in_valid = ($urandom_range(0, 99) < 70);
                bus.in_data = $urandom;
                bus.in_shamt = 5'($urandom_range(0, 31));
                bus.in_op = 3'($urandom_range(0, 7));
                bus.in_tag = 4'($urandom_range(0, 15));
            end
            bus.out_ready = ($urandom_range(0, 99) < 70);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (20) @(negedge clk);
        checkEq("random drained", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: got time limit, expected completion");
        $fatal(1, "[TB] time limit reached");
    end

endmodule

// File: doc/pipe_barrel_shifter.md
Name: pipe_barrel_shifter

Overview:
- Parametrised, fully pipelined barrel shifter with a valid/ready stream interface for the execute path of the core.
- Supports logical left, logical right, arithmetic right, rotate left and rotate right on WIDTH-bit operands.
- One shift level per pipeline stage: level k conditionally shifts by 2^k.
- Accepts one operation per cycle under no backpressure and carries a caller tag through unchanged.

Parameters:
- WIDTH, 32: operand width; power of two, minimum 8.
- TAG_W, 4: width of the pass-through tag.
- SH_W, $clog2(WIDTH): shift-amount width; derived, never overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  shifter can accept a request this cycle.
- in_data  in  WIDTH  operand.
- in_shamt  in  SH_W  shift amount, 0..WIDTH-1.
- in_op  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others reserved.
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  result.
- out_tag  out  TAG_W  tag of the request that produced out_data.
- out_carry  out  1  last bit shifted out; present only with SHIFTER_CARRY_EN.

Behaviour:
- Pipeline structure:
  - SH_W register stages, each with its own valid bit.
  - Stage k (k = 0..SH_W-1) applies the shift by 2^k when shamt[k] = 1, otherwise passes its data through.
  - Every stage holds data, shamt, op and tag.
- Latency: exactly SH_W cycles from in_valid & in_ready to out_valid, assuming out_ready stays high.
- Handshake:
  - Stage k advances when it is empty or stage k+1 advances; the last stage advances when it is empty or out_ready = 1.
  - in_ready = stage 0 advances; combinational on out_ready and the valid bits.
  - A transfer occurs only on valid & ready.
  - Full throughput: with out_ready held at 1, one result per cycle.
  - When a stage stalls, its contents and all upstream contents hold.
  - No request is dropped or duplicated; output order equals input order.
- Output stability: out_valid, out_data, out_tag and out_carry stay stable while out_valid = 1 and out_ready = 0.
- Shift semantics:
  - SLL and SRL zero-fill.
  - SRA fills with the original bit WIDTH-1.
  - ROL and ROR wrap bits around.
  - shamt = 0 returns in_data unchanged for every op.
- Reserved op codes: in_data passes through unchanged, out_carry = 0, and the request still completes with normal latency.
- Reset:
  - All valid bits clear to 0, so out_valid = 0.
  - out_data = 0, out_tag = 0, out_carry = 0.
  - in_ready = 1 in the first cycle after reset deasserts.
  - Reset mid-operation discards all in-flight requests with no partial outputs.
- Simultaneous events:
  - A full pipeline with out_ready = 1 and in_valid = 1 accepts the new request and retires the oldest in the same cycle.
  - in_valid with out_ready = 0 on a full pipeline leaves in_ready = 0.

Optional Feature:
- Macro: SHIFTER_CARRY_EN.
- With the macro defined:
  - Each stage also carries a carry bit, initialised to 0 at entry.
  - A stage that applies its shift updates carry:
    - SLL: bit WIDTH-2^k of the stage input.
    - SRL/SRA: bit 2^k-1 of the stage input.
    - ROL: bit 0 of the stage result.
    - ROR: bit WIDTH-1 of the stage result.
  - A stage that does not shift leaves carry unchanged.
  - out_carry presents the final carry value.
- Without the macro: the out_carry port and all carry registers are absent; all other behaviour is identical.

Decomposition:
- Shared package shifter_pkg:
  - Op-code localparams: OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR.
  - The op typedef (3-bit).
  - A packed stage-payload struct: data, shamt, op, tag, optional carry.
- One natural sub-module, shift_stage:
  - Parametrised by WIDTH and level index K.
  - Holds the combinational 2^K shift/rotate plus the payload and valid registers with the local advance logic.
  - The top generates SH_W instances and chains the ready signals.

Test Plan:
- WIDTH=32, SLL 0x0000_00F1 shamt 4 -> out_data 0x0000_0F10 exactly 5 cycles after acceptance; tag preserved.
- SRA 0x8000_0000 shamt 31 -> 0xFFFF_FFFF; SRL same inputs -> 0x0000_0001; ROR 0x0000_0001 shamt 1 -> 0x8000_0000; ROL 0x8000_0000 shamt 1 -> 0x0000_0001.
- Back-to-back: 8 requests with tags 0..7 and out_ready held at 1 -> 8 results on 8 consecutive cycles, tags in order.
- Backpressure: out_ready = 0 while issuing continuously -> in_ready drops after 5 accepts, outputs stay stable; release out_ready -> all results delivered in order, none lost.
- Reset asserted with 3 requests in flight -> out_valid = 0 immediately (asynchronous), no stale results after release; in_ready = 1.
- With SHIFTER_CARRY_EN: SLL 0x8000_0001 shamt 1 -> data 0x0000_0002, carry 1; SRL 0x0000_0002 shamt 2 -> carry 1; shamt 0 -> carry 0; reserved op 111 -> pass-through, carry 0.
